bcd_serial_adder: RTL
=====================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits per operand (legal 1..8).
REQ-002 SHALL have port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin an addition.
REQ-005 SHALL have port a, input, 4*DIGITS bits, BCD operand A; digit i is a[4i+3:4i], and digit 0 is the least significant.
REQ-006 SHALL have port b, input, 4*DIGITS bits, BCD operand B, same packing as a.
REQ-007 SHALL have port cin, input, 1 bit, carry into digit 0.
REQ-008 SHALL have port sum, output, 4*DIGITS bits, registered BCD result, same packing as a.
REQ-009 SHALL have port cout, output, 1 bit, registered carry out of the most significant digit.
REQ-010 SHALL have port error, output, 1 bit, registered flag set when any operand digit was greater than 9.
REQ-011 SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-012 SHALL have port done, output, 1 bit, one-cycle pulse marking result valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, ADD and DONE.
REQ-014 SHALL, in IDLE with start=1 at an edge, latch a, b and cin, clear the digit index to 0 and the error accumulator to 0, set busy=1, and go to ADD.
REQ-015 SHALL, in ADD, process exactly one digit per clock, LSD first: t = a_i + b_i + carry (5-bit); if t > 9, digit = (t + 6) mod 16 and carry = 1; otherwise digit = t and carry = 0.
REQ-016 SHALL set the error accumulator if a_i > 9 or b_i > 9 for any processed digit; the digit is still computed per REQ-015.
REQ-017 SHALL, on the edge that processes digit DIGITS-1, update sum, cout and error together, set busy=0 and go to DONE.
REQ-018 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE. Latency from the start-sampling edge to done high is DIGITS+1 edges.
REQ-019 SHALL hold sum, cout and error stable between completions; they change only per REQ-017 or reset.
REQ-020 SHALL ignore start while in ADD or DONE, with no effect on the latched operands or the result.
REQ-021 SHALL be unaffected by changes to a, b and cin after the latching edge.
REQ-022 SHALL accept start=1 held continuously as back-to-back operations, one every DIGITS+2 cycles.

Reset
REQ-023 SHALL, on resetn=0, immediately (without a clock) set state=IDLE, sum=0, cout=0, error=0, busy=0, done=0, and clear the internal index, carry and latched operands.
REQ-024 SHALL abandon any operation interrupted by reset mid-ADD, with no done pulse and no partial sum update.
REQ-025 SHALL, after resetn rises, sample start no earlier than the first rising clk edge.

Configuration
REQ-026 SHALL, when macro BCD_SEVSEG_OUT_EN is defined, add output port hex, 7*DIGITS bits, registered and active-low, with hex[7i+6:7i] showing sum digit i (segment 0 = a through 6 = g).
REQ-027 SHALL drive each hex digit blank (7'h7F) while error=1; hex SHALL reset to all blank and SHALL update on the same edge as sum.
REQ-028 SHALL, without BCD_SEVSEG_OUT_EN, omit the hex port and its logic entirely; all other behaviour is identical.

Verification (DIGITS=4)
REQ-029 SHALL cover: a=16'h0999, b=16'h0001, cin=0 -> sum=16'h1000, cout=0, error=0, done exactly 5 edges after the start edge.
REQ-030 SHALL cover: a=16'h9999, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, error=0.
REQ-031 SHALL cover: a=16'h00A5, b=16'h0004 -> error=1, sum=16'h0109, cout=0.
REQ-032 SHALL cover: start pulsed again 2 cycles after the first start, with new operands -> ignored; one done only, with the result of the first operands.
REQ-033 SHALL cover: resetn pulsed low in the third ADD cycle -> outputs 0 at once, no done; the next operation 16'h1234+16'h4321 -> sum=16'h5555.
REQ-034 SHALL cover, with BCD_SEVSEG_OUT_EN: 16'h0012+16'h0000 -> hex[6:0]=7'h24, hex[13:7]=7'h79.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if
//   Handshake and data bundle for the digit-serial BCD adder.
//   master : drives start/a/b/cin, observes the result and status
//   slave  : the adder itself
//   start        request to begin an addition
//   a, b         BCD operands, digit i at [4i+3:4i], digit 0 least significant
//   cin          carry into digit 0
//   sum, cout    registered BCD result and carry out of the top digit
//   error        registered flag, some operand digit was greater than 9
//   busy         high while digits are being processed
//   done         one-cycle pulse, result valid
//   hex          (only with BCD_SEVSEG_OUT_EN) active-low 7-segment image of sum
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  error;
  logic                  busy;
  logic                  done;
`ifdef BCD_SEVSEG_OUT_EN
  logic [7*DIGITS-1:0]   hex;

  modport master (output start, a, b, cin,
                  input  sum, cout, error, busy, done, hex);
  modport slave  (input  start, a, b, cin,
                  output sum, cout, error, busy, done, hex);
`else
  modport master (output start, a, b, cin,
                  input  sum, cout, error, busy, done);
  modport slave  (input  start, a, b, cin,
                  output sum, cout, error, busy, done);
`endif
endinterface

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Adds two DIGITS-digit BCD numbers one digit per clock, least significant
//   digit first. Operands are latched when start is seen in IDLE; the result,
//   carry and error flag update together on the edge that handles the top digit.
//   Optional macro BCD_SEVSEG_OUT_EN adds an active-low 7-segment image of sum.
// Ports
//   clk     system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     bcd_serial_adder_if.slave (start, a, b, cin, sum, cout, error,
//           busy, done, and hex when BCD_SEVSEG_OUT_EN is defined)
//
// state | meaning
// IDLE  | waiting for start; operands latched on the start edge
// ADD   | one digit per clock; busy=1
// DONE  | single cycle with done=1, start ignored
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               resetn,
  bcd_serial_adder_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state, state_nxt;
  // a_q doubles as the result accumulator: each ADD cycle shifts one operand
  // digit out at the bottom and the computed sum digit in at the top.
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           carry_q;
  logic           err_acc_q;
  logic [3:0]     cnt_q;
  logic [W-1:0]   sum_q;
  logic           cout_q;
  logic           error_q;

  logic [3:0]     a_i, b_i, dig;
  logic [4:0]     t, t6;
  logic           carry_nxt, err_nxt, last;
  logic [W-1:0]   sum_new;

  always_comb begin
    a_i       = a_q[3:0];
    b_i       = b_q[3:0];
    t         = {1'b0, a_i} + {1'b0, b_i} + {4'b0, carry_q};
    t6        = t + 5'd6;
    carry_nxt = (t > 5'd9);
    dig       = carry_nxt ? t6[3:0] : t[3:0];
    err_nxt   = err_acc_q | (a_i > 4'd9) | (b_i > 4'd9);
    last      = (cnt_q == 4'd0);
  end

  generate
    if (DIGITS == 1) begin : g_one
      assign sum_new = dig;
    end else begin : g_multi
      assign sum_new = {dig, a_q[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BCD_SEVSEG_OUT_EN
  logic [7*DIGITS-1:0] hex_q, hex_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    hex_nxt = '1;
    for (int i = 0; i < DIGITS; i++)
      hex_nxt[7*i +: 7] = err_nxt ? 7'h7F : seg7(sum_new[4*i +: 4]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  hex_q <= '1;
    else if (state == ADD && last) hex_q <= hex_nxt;
  end

  assign bus.hex = hex_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      err_acc_q <= 1'b0;
      cnt_q     <= 4'd0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q       <= bus.a;
          b_q       <= bus.b;
          carry_q   <= bus.cin;
          err_acc_q <= 1'b0;
          cnt_q     <= 4'(DIGITS - 1);
        end
        ADD: begin
          a_q       <= sum_new;
          b_q       <= b_q >> 4;
          carry_q   <= carry_nxt;
          err_acc_q <= err_nxt;
          cnt_q     <= cnt_q - 4'd1;
          if (last) begin
            sum_q   <= sum_new;
            cout_q  <= carry_nxt;
            error_q <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.error = error_q;
  assign bus.busy  = (state == ADD);
  assign bus.done  = (state == DONE);
endmodule
